// File: rtl/ping_pkg.sv
// Shared types and default widths for the ping sequencer.
package ping_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LISTEN = 2'd1,
        ACCUM  = 2'd2,
        REPORT = 2'd3
    } ping_state_e;

    localparam int PERIOD_W_DEF = 12;
    localparam int NPING_W_DEF  = 4;
    localparam int GUARD_DEF    = 0;
    localparam int OUT_W_DEF    = 24;

endpackage

// File: rtl/ping_sequencer_if.sv
// Command, strobe and result handshake bundle of the ping sequencer.
// With PING_HIT_COUNT_EN defined it also carries res_hits.
interface ping_sequencer_if #(
    parameter int OUT_W = ping_pkg::OUT_W_DEF
`ifdef PING_HIT_COUNT_EN
    , parameter int NPING_W = ping_pkg::NPING_W_DEF
`endif
);
    logic             start;
    logic             stop;
    logic             echo_stb;
    logic             tx_stb;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic [OUT_W-1:0] res_data;
`ifdef PING_HIT_COUNT_EN
    logic [NPING_W:0] res_hits;

    modport master (
        input  start, stop, echo_stb, res_ready,
        output tx_stb, busy, res_valid, res_data, res_hits
    );
    modport slave (
        output start, stop, echo_stb, res_ready,
        input  tx_stb, busy, res_valid, res_data, res_hits
    );
`else
    modport master (
        input  start, stop, echo_stb, res_ready,
        output tx_stb, busy, res_valid, res_data
    );
    modport slave (
        output start, stop, echo_stb, res_ready,
        input  tx_stb, busy, res_valid, res_data
    );
`endif
endinterface

// File: rtl/ping_window.sv
// Ping window: window counter, TX strobe, guard blanking and first/last echo capture.
module ping_window #(
    parameter int PERIOD_W = 12,
    parameter int GUARD    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                restart_i,
    input  logic                listen_i,
    input  logic                echo_stb_i,
    output logic                tx_stb_o,
    output logic                win_last_o,
    output logic                hit_o,
    output logic [PERIOD_W-1:0] first_o,
    output logic [PERIOD_W-1:0] last_o
);
    logic [PERIOD_W-1:0] win_cnt_q, win_cnt_d;
    logic [PERIOD_W-1:0] first_q, first_d, last_q, last_d;
    logic                hit_q, hit_d, tx_stb_q;
    logic                guard_ok_s;

    if (GUARD == 0) begin : g_no_guard
        assign guard_ok_s = 1'b1;
    end else begin : g_guard
        assign guard_ok_s = (win_cnt_q >= PERIOD_W'(GUARD));
    end

    // Next window count and echo capture; leaving LISTEN clears the ping state.
    always_comb begin
        win_cnt_d = win_cnt_q;
        first_d   = first_q;
        last_d    = last_q;
        hit_d     = hit_q;
        if (restart_i || !listen_i) begin
            win_cnt_d = {PERIOD_W{1'b0}};
            hit_d     = 1'b0;
        end else begin
            win_cnt_d = win_cnt_q + PERIOD_W'(1'b1);
            if (echo_stb_i && guard_ok_s) begin
                if (!hit_q) begin
                    first_d = win_cnt_q;
                end else begin
                    first_d = first_q;
                end
                hit_d  = 1'b1;
                last_d = win_cnt_q;
            end else begin
                hit_d = hit_q;
            end
        end
    end

    // Window registers; tx_stb is high in the cycle where win_cnt is zero after a restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q <= {PERIOD_W{1'b0}};
            first_q   <= {PERIOD_W{1'b0}};
            last_q    <= {PERIOD_W{1'b0}};
            hit_q     <= 1'b0;
            tx_stb_q  <= 1'b0;
        end else begin
            win_cnt_q <= win_cnt_d;
            first_q   <= first_d;
            last_q    <= last_d;
            hit_q     <= hit_d;
            tx_stb_q  <= restart_i;
        end
    end

    assign tx_stb_o   = tx_stb_q;
    assign win_last_o = listen_i && (win_cnt_q == {PERIOD_W{1'b1}});
    assign hit_o      = hit_q;
    assign first_o    = first_q;
    assign last_o     = last_q;
endmodule

// File: rtl/ping_sequencer.sv
// Ping sequencer top: accumulates first/last echo times over 2^NPING_W pings, reports the averaged sum.
// Optional PING_HIT_COUNT_EN adds res_hits, the number of pings with a qualifying echo.
module ping_sequencer
    import ping_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF,
    parameter int NPING_W  = NPING_W_DEF,
    parameter int GUARD    = GUARD_DEF,
    parameter int OUT_W    = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    ping_sequencer_if.master bus
);
    localparam int SUM_W = PERIOD_W + NPING_W;

    ping_state_e         state_q, state_d;
    logic                run_q, run_d;
    logic [NPING_W-1:0]  ping_idx_q, ping_idx_d;
    logic [SUM_W-1:0]    sum_begin_q, sum_begin_d, sum_end_q, sum_end_d;
    logic                res_valid_q, res_valid_d;
    logic [OUT_W-1:0]    res_data_q, res_data_d;
    logic                busy_q;
    logic                restart_s, listen_s, win_last_s, hit_s, tx_stb_s;
    logic [PERIOD_W-1:0] first_s, last_s;
`ifdef PING_HIT_COUNT_EN
    localparam int HITS_W = NPING_W + 1;
    logic [HITS_W-1:0]   hits_q, hits_d, res_hits_q, res_hits_d;
`endif

    assign listen_s = (state_q == LISTEN);

    ping_window #(
        .PERIOD_W (PERIOD_W),
        .GUARD    (GUARD)
    ) u_window (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart_i  (restart_s),
        .listen_i   (listen_s),
        .echo_stb_i (bus.echo_stb),
        .tx_stb_o   (tx_stb_s),
        .win_last_o (win_last_s),
        .hit_o      (hit_s),
        .first_o    (first_s),
        .last_o     (last_s)
    );

    // Sequencer next state, accumulation and result latching; stop outranks start.
    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        ping_idx_d  = ping_idx_q;
        sum_begin_d = sum_begin_q;
        sum_end_d   = sum_end_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        restart_s   = 1'b0;
`ifdef PING_HIT_COUNT_EN
        hits_d      = hits_q;
        res_hits_d  = res_hits_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d     = LISTEN;
                    run_d       = 1'b1;
                    ping_idx_d  = {NPING_W{1'b0}};
                    sum_begin_d = {SUM_W{1'b0}};
                    sum_end_d   = {SUM_W{1'b0}};
                    restart_s   = 1'b1;
`ifdef PING_HIT_COUNT_EN
                    hits_d      = {HITS_W{1'b0}};
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            LISTEN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    run_d   = 1'b0;
                end else if (win_last_s) begin
                    state_d = ACCUM;
                end else begin
                    state_d = LISTEN;
                end
            end
            ACCUM: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    run_d   = 1'b0;
                end else begin
                    if (hit_s) begin
                        sum_begin_d = sum_begin_q + SUM_W'(first_s);
                        sum_end_d   = sum_end_q + SUM_W'(last_s);
`ifdef PING_HIT_COUNT_EN
                        hits_d      = hits_q + HITS_W'(1'b1);
`endif
                    end else begin
                        sum_begin_d = sum_begin_q;
                        sum_end_d   = sum_end_q;
                    end
                    ping_idx_d = ping_idx_q + NPING_W'(1'b1);
                    if (ping_idx_q == {NPING_W{1'b1}}) begin
                        res_valid_d = 1'b1;
                        res_data_d  = OUT_W'(sum_begin_d >> NPING_W) + OUT_W'(sum_end_d >> NPING_W);
`ifdef PING_HIT_COUNT_EN
                        res_hits_d  = hits_d;
`endif
                        state_d     = REPORT;
                    end else begin
                        restart_s = 1'b1;
                        state_d   = LISTEN;
                    end
                end
            end
            REPORT: begin
                if (bus.stop) begin
                    run_d = 1'b0;
                end else begin
                    run_d = run_q;
                end
                if (res_valid_q && bus.res_ready) begin
                    res_valid_d = 1'b0;
                    if (run_q && !bus.stop) begin
                        state_d     = LISTEN;
                        ping_idx_d  = {NPING_W{1'b0}};
                        sum_begin_d = {SUM_W{1'b0}};
                        sum_end_d   = {SUM_W{1'b0}};
                        restart_s   = 1'b1;
`ifdef PING_HIT_COUNT_EN
                        hits_d      = {HITS_W{1'b0}};
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = REPORT;
                end
            end
            default: begin
                state_d = IDLE;
                run_d   = 1'b0;
            end
        endcase
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            run_q       <= 1'b0;
            ping_idx_q  <= {NPING_W{1'b0}};
            sum_begin_q <= {SUM_W{1'b0}};
            sum_end_q   <= {SUM_W{1'b0}};
            res_valid_q <= 1'b0;
            res_data_q  <= {OUT_W{1'b0}};
            busy_q      <= 1'b0;
`ifdef PING_HIT_COUNT_EN
            hits_q      <= {HITS_W{1'b0}};
            res_hits_q  <= {HITS_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            ping_idx_q  <= ping_idx_d;
            sum_begin_q <= sum_begin_d;
            sum_end_q   <= sum_end_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            busy_q      <= (state_d != IDLE);
`ifdef PING_HIT_COUNT_EN
            hits_q      <= hits_d;
            res_hits_q  <= res_hits_d;
`endif
        end
    end

    assign bus.tx_stb    = tx_stb_s;
    assign bus.busy      = busy_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
`ifdef PING_HIT_COUNT_EN
    assign bus.res_hits  = res_hits_q;
`endif
endmodule

// File: tb/tb_ping_sequencer.sv
// Randomized bench for ping_sequencer against a per-ping first/last echo model.
module tb_ping_sequencer;
    localparam int PERIOD_W = 6;
    localparam int NPING_W  = 2;
    localparam int GUARD    = 2;
    localparam int OUT_W    = 24;
    localparam int WIN      = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [WIN-1:0] masks [4];

`ifdef PING_HIT_COUNT_EN
    ping_sequencer_if #(.OUT_W(OUT_W), .NPING_W(NPING_W)) bus ();
`else
    ping_sequencer_if #(.OUT_W(OUT_W)) bus ();
`endif

    ping_sequencer #(
        .PERIOD_W (PERIOD_W),
        .NPING_W  (NPING_W),
        .GUARD    (GUARD),
        .OUT_W    (OUT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Each ping reduces to its earliest and latest echo at or beyond the guard.
    function automatic void model(output int res, output int hits);
        int sb, se, first, last;
        sb = 0; se = 0; hits = 0;
        for (int p = 0; p < 4; p++) begin
            first = -1; last = -1;
            for (int pos = GUARD; pos < WIN; pos++) begin
                if (masks[p][pos]) begin
                    if (first < 0) first = pos;
                    last = pos;
                end
            end
            if (first >= 0) begin
                sb += first; se += last; hits++;
            end
        end
        res = (sb >> NPING_W) + (se >> NPING_W);
    endfunction

    function automatic logic [WIN-1:0] rnd_mask();
        logic [WIN-1:0] m;
        case ($urandom_range(0, 3))
            0: m = '0;
            1: begin m = '0; m[$urandom_range(0, WIN-1)] = 1'b1; end
            2: begin m = '0; m[$urandom_range(0, WIN-1)] = 1'b1; m[$urandom_range(0, WIN-1)] = 1'b1; end
            default: m = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        endcase
        return m;
    endfunction

    task automatic rnd_masks;
        for (int p = 0; p < 4; p++) masks[p] = rnd_mask();
    endtask

    task automatic do_start;
        bus.start = 1'b1;
        step;
        bus.start = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        @(negedge clk);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_tx"}, bus.tx_stb, 0);
        chk({tag, "_valid"}, bus.res_valid, 0);
        step;
    endtask

    // One ping window plus its accumulate cycle; stop_at >= 0 aborts at that window position.
    task automatic run_ping(input int p, input int stop_at);
        for (int pos = 0; pos < WIN; pos++) begin
            bus.echo_stb = masks[p][pos];
            bus.start    = ($urandom_range(0, 40) == 0);
            bus.stop     = (pos == stop_at);
            @(negedge clk);
            chk("tx_stb", bus.tx_stb, (pos == 0));
            chk("busy", bus.busy, 1);
            chk("valid_listen", bus.res_valid, 0);
            step;
            if (pos == stop_at) begin
                bus.stop = 1'b0; bus.start = 1'b0; bus.echo_stb = 1'b0;
                return;
            end
        end
        bus.echo_stb = 1'($urandom);
        bus.start    = 1'($urandom);
        @(negedge clk);
        chk("tx_accum", bus.tx_stb, 0);
        chk("busy_accum", bus.busy, 1);
        step;
        bus.echo_stb = 1'b0;
        bus.start    = 1'b0;
    endtask

    task automatic measure(input int hold, input bit stop_rep);
        int r, h;
        model(r, h);
        for (int p = 0; p < 4; p++) run_ping(p, -1);
        for (int k = 0; k <= hold; k++) begin
            bus.res_ready = (k == hold);
            bus.echo_stb  = 1'($urandom);
            bus.start     = 1'($urandom);
            bus.stop      = stop_rep && (k == hold / 2);
            @(negedge clk);
            chk("res_valid", bus.res_valid, 1);
            chk("res_data", bus.res_data, r);
`ifdef PING_HIT_COUNT_EN
            chk("res_hits", bus.res_hits, h);
`endif
            chk("tx_report", bus.tx_stb, 0);
            chk("busy_report", bus.busy, 1);
            step;
        end
        bus.res_ready = 1'b0; bus.echo_stb = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
        if (stop_rep) begin
            for (int i = 0; i < 3; i++) chk_idle("after_report_stop");
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.echo_stb = 1'b0; bus.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", bus.tx_stb, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.res_valid, 0);
        chk("rst_data", bus.res_data, 0);
        step;
        rst_n = 1'b1;
        chk_idle("idle");

        bus.start = 1'b1; bus.stop = 1'b1;
        step;
        bus.start = 1'b0; bus.stop = 1'b0;
        chk_idle("start_stop");
        bus.stop = 1'b1;
        step;
        bus.stop = 1'b0;
        chk_idle("stop_idle");

        // Fixed echoes at 10, 15, 20 every ping, then a run of random measurements.
        for (int p = 0; p < 4; p++) begin
            masks[p] = '0; masks[p][10] = 1'b1; masks[p][15] = 1'b1; masks[p][20] = 1'b1;
        end
        do_start;
        measure(0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rnd_masks;
            measure($urandom_range(0, 3), 1'b0);
        end

        for (int p = 0; p < 4; p++) masks[p] = '0;
        measure(0, 1'b0);
        for (int p = 0; p < 4; p++) begin masks[p] = '0; masks[p][1] = 1'b1; end
        measure(1, 1'b0);
        for (int p = 0; p < 4; p++) begin masks[p] = '0; masks[p][2] = 1'b1; masks[p][63] = 1'b1; end
        measure(0, 1'b0);
        for (int p = 0; p < 4; p++) begin
            masks[p] = '0;
            if (p < 2) for (int b = 8; b <= 24; b++) masks[p][b] = 1'b1;
        end
        measure(2, 1'b0);

        // Long back-pressure with stop arriving while the result is pending.
        rnd_masks;
        measure(100, 1'b1);

        // Abort mid-ping 2; the next result must use fresh pings only.
        rnd_masks;
        do_start;
        run_ping(0, -1);
        run_ping(1, -1);
        run_ping(2, 30);
        for (int i = 0; i < 4; i++) begin
            bus.echo_stb = 1'($urandom);
            chk_idle("after_abort");
        end
        bus.echo_stb = 1'b0;
        rnd_masks;
        do_start;
        measure(1, 1'b1);

        // Asynchronous reset in the middle of a window.
        rnd_masks;
        do_start;
        run_ping(0, -1);
        repeat (20) step;
        rst_n = 1'b0;
        #1;
        chk("arst_tx", bus.tx_stb, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_valid", bus.res_valid, 0);
        chk("arst_data", bus.res_data, 0);
`ifdef PING_HIT_COUNT_EN
        chk("arst_hits", bus.res_hits, 0);
`endif
        step;
        rst_n = 1'b1;
        chk_idle("after_arst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
